// File: rtl/prim_subreg_bank.sv
// Bank of software registers with per-register access policy, hardware update merging
// and a single-outstanding request/response handshake.
package prim_subreg_pkg;
  typedef enum logic [2:0] {
    SwAccessRW,
    SwAccessRO,
    SwAccessWO,
    SwAccessW1C,
    SwAccessW1S,
    SwAccessW0C,
    SwAccessRC
  } sw_access_e;
endpackage

module prim_subreg_bank
  import prim_subreg_pkg::*;
#(
  parameter int unsigned NumRegs = 8,
  parameter int unsigned DW = 32,
  parameter sw_access_e RegAccess [NumRegs] = '{default: SwAccessRW},
  parameter logic [NumRegs-1:0][DW-1:0] RegResval = '0,
  localparam int unsigned AW = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW:0]           req_addr_i,
  input  logic [DW-1:0]         req_wdata_i,
  input  logic [DW/8-1:0]       req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DW-1:0]         rsp_rdata_o,
  output logic                  rsp_err_o,
  input  logic [NumRegs-1:0]    hw_de_i,
  input  logic [NumRegs*DW-1:0] hw_d_i,
  output logic [NumRegs*DW-1:0] reg_q_o,
  output logic [NumRegs-1:0]    reg_qe_o
);

  typedef enum logic {StIdle, StResp} state_e;

  state_e        stateQ, stateD;
  logic          accept;
  logic          inRange;
  logic [AW-1:0] idx;
  logic [DW-1:0] mask;
  logic [DW-1:0] regQ [NumRegs];
  logic [DW-1:0] rspRdataQ, rspRdataD;
  logic          rspErrQ, rspErrD;

  assign inRange = 32'(req_addr_i) < NumRegs;
  assign idx     = req_addr_i[AW-1:0];

  for (genvar gi = 0; gi < DW / 8; gi++) begin : gen_mask
    assign mask[8*gi +: 8] = {8{req_be_i[gi]}};
  end

  always_comb begin
    stateD      = stateQ;
    req_ready_o = 1'b0;
    accept      = 1'b0;
    case (stateQ)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept = 1'b1;
          stateD = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // Response captures the pre-edge register value; writes always return zero data.
  always_comb begin
    rspRdataD = rspRdataQ;
    rspErrD   = rspErrQ;
    if (accept) begin
      rspRdataD = '0;
      rspErrD   = 1'b0;
      if (!inRange) begin
        rspErrD = 1'b1;
      end else if (req_we_i) begin
        rspErrD = (RegAccess[idx] == SwAccessRO) || (RegAccess[idx] == SwAccessRC);
      end else if (RegAccess[idx] != SwAccessWO) begin
        rspRdataD = regQ[idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateQ    <= StIdle;
      rspRdataQ <= '0;
      rspErrQ   <= 1'b0;
    end else begin
      stateQ    <= stateD;
      rspRdataQ <= rspRdataD;
      rspErrQ   <= rspErrD;
    end
  end

  assign rsp_valid_o = (stateQ == StResp);
  assign rsp_rdata_o = rspRdataQ;
  assign rsp_err_o   = rspErrQ;

  for (genvar gi = 0; gi < NumRegs; gi++) begin : gen_reg
    localparam sw_access_e Acc = RegAccess[gi];

    logic          hit, swWr, swRd, wrOk, swUpd, swWins;
    logic [DW-1:0] swVal, wdMasked;
    logic [DW-1:0] q;
    logic          qe;

    assign hit      = accept && inRange && (idx == AW'(gi));
    assign swWr     = hit && req_we_i;
    assign swRd     = hit && !req_we_i;
    assign wrOk     = swWr && (Acc != SwAccessRO) && (Acc != SwAccessRC);
    assign wdMasked = req_wdata_i & mask;

    always_comb begin
      swVal = q;
      swUpd = 1'b0;
      case (Acc)
        SwAccessRW, SwAccessWO: begin
          swUpd = wrOk;
          swVal = (q & ~mask) | wdMasked;
        end
        SwAccessW1S: begin
          swUpd = wrOk;
          swVal = q | wdMasked;
        end
        SwAccessW1C: begin
          swUpd = wrOk;
          swVal = q & ~wdMasked;
        end
        SwAccessW0C: begin
          swUpd = wrOk;
          swVal = q & ~(~req_wdata_i & mask);
        end
        SwAccessRC: begin
          swUpd = swRd;
          swVal = '0;
        end
        default: ;
      endcase
    end

    // Set-style policies override hardware; clear-style policies yield so no event is lost.
    // An all-zero byte enable changes nothing, so it never masks a hardware load.
    assign swWins = swUpd && (|req_be_i) &&
                    ((Acc == SwAccessRW) || (Acc == SwAccessWO) || (Acc == SwAccessW1S));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        q  <= RegResval[gi];
        qe <= 1'b0;
      end else begin
        qe <= wrOk;
        if (swWins) begin
          q <= swVal;
        end else if (hw_de_i[gi]) begin
          q <= hw_d_i[gi*DW +: DW];
        end else if (swUpd) begin
          q <= swVal;
        end
      end
    end

    assign regQ[gi]              = q;
    assign reg_q_o[gi*DW +: DW]  = q;
    assign reg_qe_o[gi]          = qe;
  end

endmodule
